// File: rtl/cordic_nco_driver.sv
// Phase-accumulator NCO front end: issues one angle at a time to an external cosine unit
// and buffers the returned samples in a small FIFO for a ready/valid consumer.
module cordic_nco_driver #(
  parameter int unsigned BIT_WIDTH        = 16,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned LOG_2_FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BIT_WIDTH-1:0] phase_inc,
  input  logic                 phase_load,
  input  logic [BIT_WIDTH-1:0] phase_init,
  input  logic                 cos_ready,
  input  logic                 cos_done,
  input  logic [BIT_WIDTH-1:0] cos_value,
  output logic                 cos_start,
  output logic [BIT_WIDTH-1:0] cos_angle,
  output logic [BIT_WIDTH-1:0] sample_out,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitDone} state_e;

  localparam int unsigned CntW = LOG_2_FIFO_DEPTH + 1;
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [LOG_2_FIFO_DEPTH-1:0] PtrOne = LOG_2_FIFO_DEPTH'(1);

  state_e                      state_q, state_d;
  logic [BIT_WIDTH-1:0]        phase_q, phase_d;
  logic [BIT_WIDTH-1:0]        angle_q, angle_d;
  logic                        start_q, start_d;
  logic                        done_q;
  logic [BIT_WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [LOG_2_FIFO_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             count_q, count_d;
  logic                        push, pop;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    angle_d = angle_q;
    start_d = 1'b0;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        // A load in the same cycle as an issue request wins; the issue waits a cycle.
        if (phase_load) begin
          phase_d = phase_init;
        end else if (enable && cos_ready && (count_q < FifoFull)) begin
          state_d = StIssue;
          angle_d = phase_q;
          phase_d = phase_q + phase_inc;
          start_d = 1'b1;
        end
      end
      StIssue: state_d = StWaitAck;
      StWaitAck: begin
        if (!cos_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        // Only a fresh rising edge counts; a done level left over from before is ignored.
        if (cos_done && !done_q) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = (count_q != '0) && sample_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (!push && pop) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      angle_q  <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      angle_q <= angle_d;
      start_q <= start_d;
      done_q  <= cos_done;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= cos_value;
  end

  assign sample_valid = (count_q != '0);
  assign sample_out   = sample_valid ? mem_q[rd_ptr_q] : '0;
  assign cos_start    = start_q;
  assign cos_angle    = angle_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_cordic_nco_driver.sv
// Directed scenarios with random phase steps and cosine values, checked against a
// queue-based model of the expected angles and sample stream.
module tb_cordic_nco_driver;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] phase_inc;
  logic        phase_load;
  logic [15:0] phase_init;
  logic        cos_ready;
  logic        cos_done;
  logic [15:0] cos_value;
  logic        cos_start;
  logic [15:0] cos_angle;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;

  cordic_nco_driver #(
    .BIT_WIDTH       (16),
    .FIFO_DEPTH      (4),
    .LOG_2_FIFO_DEPTH(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .phase_inc   (phase_inc),
    .phase_load  (phase_load),
    .phase_init  (phase_init),
    .cos_ready   (cos_ready),
    .cos_done    (cos_done),
    .cos_value   (cos_value),
    .cos_start   (cos_start),
    .cos_angle   (cos_angle),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy        (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_start = 0;
  int n_pop = 0;
  int start_cyc = 0;
  bit mon_en = 0;

  logic [15:0] model_phase = '0;
  logic [15:0] exp_q[$];
  logic [15:0] angle_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_starts(input int target, input int limit);
    int n = 0;
    while (n_start < target && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    if (n_start < target) chk("timeout_start", 32'(n_start), 32'(target));
  endtask

  task automatic wait_idle_empty(input int limit);
    int n = 0;
    while ((busy || sample_valid) && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    if (busy || sample_valid) chk("timeout_idle", {30'd0, busy, sample_valid}, 32'd0);
  endtask

  // Monitor plus cosine-unit stub; everything here happens on the falling edge.
  initial begin
    bit          inflight = 0;
    bit          stub_active = 0;
    int          stub_age = 0;
    logic [15:0] exp_v;
    cos_ready = 1'b1;
    cos_done  = 1'b0;
    cos_value = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("valid_vs_model", 32'(sample_valid), 32'(exp_q.size() != 0));
        if (reset) begin
          model_phase = '0;
          exp_q.delete();
          inflight = 0;
        end else begin
          if (phase_load && !busy) model_phase = phase_init;
          if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
              chk("pop_from_empty_model", 32'(sample_out), 32'hFFFF_FFFF);
            end else begin
              exp_v = exp_q.pop_front();
              chk("sample_order", 32'(sample_out), 32'(exp_v));
            end
            n_pop++;
          end
          if (cos_start) begin
            chk("cos_angle_model", 32'(cos_angle), 32'(model_phase));
            angle_log.push_back(cos_angle);
            model_phase = model_phase + phase_inc;
            n_start++;
            start_cyc = cyc;
            inflight = 1;
          end
        end
      end
      if (stub_active) begin
        stub_age++;
        if (stub_age == 2) cos_ready = 1'b0;
        if (stub_age == 18) begin
          cos_done = 1'b1;
          if (inflight && !reset) begin
            exp_q.push_back(cos_value);
            inflight = 0;
          end
        end
        if (stub_age == 19) begin
          cos_done    = 1'b0;
          cos_ready   = 1'b1;
          stub_active = 0;
        end
      end else if (cos_start) begin
        stub_active = 1;
        stub_age    = 0;
        cos_value   = 16'($urandom);
      end
    end
  end

  initial begin
    logic [15:0] sweep_exp [5];
    int base;
    int pop_base;
    int g;
    sweep_exp = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
    reset = 1'b1;
    enable = 1'b0;
    phase_inc = '0;
    phase_load = 1'b0;
    phase_init = '0;
    sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cos_start", 32'(cos_start), 32'd0);
    chk("rst_cos_angle", 32'(cos_angle), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    mon_en = 1;

    // Quarter-turn sweep with wrap.
    angle_log.delete();
    n_pop = 0;
    phase_inc = 16'h4000;
    sample_ready = 1'b1;
    enable = 1'b1;
    wait_starts(5, 130);
    enable = 1'b0;
    wait_idle_empty(60);
    chk("sweep_len", 32'(angle_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < angle_log.size(); i++)
      chk("sweep_angle", 32'(angle_log[i]), 32'(sweep_exp[i]));
    chk("sweep_pops", 32'(n_pop), 32'd5);

    // Backpressure fills the FIFO and stops issuing.
    phase_inc = 16'($urandom);
    sample_ready = 1'b0;
    base = n_start;
    enable = 1'b1;
    repeat (150) @(posedge clk);
    #2;
    chk("bp_starts", 32'(n_start - base), 32'd4);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_valid", 32'(sample_valid), 32'd1);

    // One pop frees a slot and lets a fifth issue through.
    sample_ready = 1'b1;
    @(posedge clk); #2;
    sample_ready = 1'b0;
    wait_starts(base + 5, 10);
    chk("release_issue", 32'(n_start - base), 32'd5);
    enable = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    sample_ready = 1'b1;
    wait_idle_empty(20);
    sample_ready = 1'b0;

    // Load beats issue in the same cycle.
    phase_init = 16'h1234;
    phase_load = 1'b1;
    enable = 1'b1;
    base = n_start;
    @(posedge clk); #2;
    phase_load = 1'b0;
    chk("load_no_start", 32'(cos_start), 32'd0);
    wait_starts(base + 1, 5);
    chk("load_angle", 32'(cos_angle), 32'h1234);
    enable = 1'b0;
    g = 0;
    while (!sample_valid && g < 30) begin
      @(posedge clk); #2;
      g++;
    end
    chk("no_abort_valid", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    wait_idle_empty(10);
    sample_ready = 1'b0;

    // Reset while waiting for done discards the conversion.
    base = n_start;
    enable = 1'b1;
    wait_starts(base + 1, 5);
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_angle", 32'(cos_angle), 32'd0);
    repeat (25) @(posedge clk);
    #2;
    chk("mid_rst_no_push", 32'(sample_valid), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    // Push and pop on the same edge with one entry held.
    phase_inc = 16'($urandom);
    sample_ready = 1'b0;
    base = n_start;
    enable = 1'b1;
    wait_starts(base + 2, 50);
    enable = 1'b0;
    chk("pp_one_held", 32'(sample_valid), 32'd1);
    g = 0;
    while (cyc != start_cyc + 18 && g < 40) begin
      @(posedge clk); #2;
      g++;
    end
    pop_base = n_pop;
    sample_ready = 1'b1;
    @(posedge clk); #2;
    sample_ready = 1'b0;
    chk("pp_still_valid", 32'(sample_valid), 32'd1);
    chk("pp_one_pop", 32'(n_pop - pop_base), 32'd1);
    sample_ready = 1'b1;
    @(posedge clk); #2;
    sample_ready = 1'b0;
    chk("pp_count_was_one", 32'(sample_valid), 32'd0);
    chk("pp_two_pops", 32'(n_pop - pop_base), 32'd2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_nco_driver.md
CORDIC_NCO_DRIVER -- requirements
Module: cordic_nco_driver

Interface
REQ-001 Parameter BIT_WIDTH, default 16: width of phase, angle and sample words.
REQ-002 Parameter FIFO_DEPTH, default 4: number of output sample FIFO entries; power of two, at least 2.
REQ-003 Parameter LOG_2_FIFO_DEPTH, default 2: log2(FIFO_DEPTH).
REQ-004 Ports SHALL be as listed below, one per line (name, direction, width, meaning).
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new conversions to be issued.
- phase_inc  in  BIT_WIDTH  unsigned phase step added after each issue.
- phase_load  in  1  load request for the phase accumulator.
- phase_init  in  BIT_WIDTH  value loaded into the phase accumulator.
- cos_ready  in  1  downstream cosine unit can accept start.
- cos_done  in  1  downstream cosine unit result valid.
- cos_value  in  BIT_WIDTH  signed cosine result.
- cos_start  out  1  one-cycle start pulse to the cosine unit.
- cos_angle  out  BIT_WIDTH  angle presented with cos_start.
- sample_out  out  BIT_WIDTH  signed FIFO head sample.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts sample_out.
- busy  out  1  FSM not in IDLE.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_ACK and WAIT_DONE; only one conversion SHALL be outstanding at any time.
REQ-006 IDLE with phase_load=1: phase <= phase_init and remain IDLE; load SHALL take priority over issue in the same cycle.
REQ-007 phase_load SHALL be ignored outside IDLE.
REQ-008 IDLE with enable=1, phase_load=0, cos_ready=1 and fifo_count<FIFO_DEPTH: go to ISSUE.
REQ-009 On the IDLE->ISSUE transition: latch cos_angle <= phase and update phase <= phase + phase_inc, modulo 2^BIT_WIDTH (no saturation).
REQ-010 In ISSUE, cos_start SHALL be 1 for exactly that one cycle (registered output); next state WAIT_ACK.
REQ-011 In WAIT_ACK, cos_start SHALL be 0; when cos_ready=0 (unit accepted) go to WAIT_DONE.
REQ-012 In WAIT_DONE, a rising edge of cos_done (cos_done=1 this cycle, 0 the previous cycle) SHALL push cos_value into the FIFO and return to IDLE.
REQ-013 A level-high cos_done already present on entry to WAIT_DONE SHALL NOT be captured.
REQ-014 Deasserting enable during ISSUE, WAIT_ACK or WAIT_DONE SHALL NOT abort the conversion; the result is still stored.
REQ-015 cos_angle SHALL hold its value until the next issue.
REQ-016 The FIFO SHALL be first-in first-out; sample_out is the head entry, and sample_valid = (fifo_count != 0).
REQ-017 A pop SHALL occur when sample_valid and sample_ready are both 1; a push on a capture cycle is visible on sample_valid the following cycle.
REQ-018 A simultaneous push and pop SHALL leave fifo_count unchanged, with both operations taking effect.
REQ-019 The FIFO SHALL never overflow, because issue is gated on fifo_count<FIFO_DEPTH; when empty, sample_ready SHALL have no effect.
REQ-020 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 busy SHALL be 1 in every state except IDLE.

Reset
REQ-022 reset SHALL be synchronous and active-high, and SHALL override all other inputs.
REQ-023 Reset values: FSM=IDLE, phase=0, cos_start=0, cos_angle=0, FIFO empty (pointers and count 0), sample_valid=0, sample_out=0, busy=0, cos_done edge register=0.
REQ-024 Reset mid-conversion SHALL discard the in-flight result; no push occurs from that conversion.

Verification
REQ-025 The bench SHALL use BIT_WIDTH=16, FIFO_DEPTH=4 and a cosine stub with cos_ready low 2 cycles after start and a 1-cycle cos_done pulse 18 cycles after start.
REQ-026 Sweep: phase_inc=0x4000, enable=1, sample_ready=1 -> cos_angle sequence 0x0000, 0x4000, 0x8000, 0xC000, 0x0000 (wrap); samples appear in issue order.
REQ-027 Backpressure: sample_ready=0 -> exactly 4 cos_start pulses, then none; busy=0; sample_valid=1.
REQ-028 Backpressure release: after the REQ-027 condition, sample_ready=1 for 1 cycle -> a 5th issue follows.
REQ-029 Load priority: in IDLE with phase_load=1, phase_init=0x1234 and enable=1 on the same cycle -> no cos_start that cycle; the next issue shows cos_angle=0x1234.
REQ-030 Reset mid-WAIT_DONE: assert reset 5 cycles after cos_start -> FIFO stays empty and no push when the stub's done arrives; FSM=IDLE.
REQ-031 Simultaneous push/pop: fifo_count=1 with sample_ready=1 on the capture cycle -> count stays 1 and the older sample is popped first.
